// File: rtl/image_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous image ROM between NUM_REQ pixel requesters.
// Optional burst lock guarded by ROM_ARB_LOCK_EN; grant/address registered, data returns two cycles after request.
module image_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   addr,
`ifdef ROM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]             lock,
`endif
  input  logic [11:0]                    rom_rgb,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [ADDR_BITS-1:0]           rom_addr,
  output logic [11:0]                    rgb,
  output logic [NUM_REQ-1:0]             rgb_valid
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]        ptr;
  logic [PW-1:0]        cur_idx;
  logic [PW-1:0]        sel_idx;
  logic                 sel_vld;
  logic                 hold;
  logic [PW-1:0]        grant_idx;
  logic                 grant_vld;
  logic [PW-1:0]        ptr_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic [ADDR_BITS-1:0] addr_nxt;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int tmp;
    sel_vld = 1'b0;
    sel_idx = '0;
    tmp     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      tmp = int'(ptr) + k;
      if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
      if (req[PW'(tmp)]) begin
        sel_vld = 1'b1;
        sel_idx = PW'(tmp);
      end
    end
  end

`ifdef ROM_ARB_LOCK_EN
  assign hold = |(gnt & req & lock);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    grant_vld = hold | sel_vld;
    grant_idx = hold ? cur_idx : sel_idx;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    addr_nxt  = rom_addr;
    if (grant_vld) begin
      gnt_nxt  = NUM_REQ'(1) << grant_idx;
      addr_nxt = addr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
    end
    // A locked re-grant leaves the pointer where the original grant put it.
    if (sel_vld && !hold) begin
      if (int'(sel_idx) == NUM_REQ - 1) ptr_nxt = '0;
      else                              ptr_nxt = PW'(int'(sel_idx) + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cur_idx   <= '0;
      gnt       <= '0;
      rom_addr  <= '0;
      rgb_valid <= '0;
    end else begin
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      rom_addr  <= addr_nxt;
      rgb_valid <= gnt;
      if (grant_vld) cur_idx <= grant_idx;
    end
  end

  assign rgb = rom_rgb;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed bench for image_rom_arbiter with a one-cycle registered ROM model.
module tb_image_rom_arbiter;
  localparam int N  = 4;
  localparam int AB = 12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AB-1:0] addr;
  logic [N-1:0]    lock;
  logic [11:0]     rom_rgb;
  logic [N-1:0]    gnt;
  logic [AB-1:0]   rom_addr;
  logic [11:0]     rgb;
  logic [N-1:0]    rgb_valid;

  int checks = 0;
  int errors = 0;

  image_rom_arbiter #(.NUM_REQ(N), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr),
`ifdef ROM_ARB_LOCK_EN
    .lock(lock),
`endif
    .rom_rgb(rom_rgb), .gnt(gnt), .rom_addr(rom_addr),
    .rgb(rgb), .rgb_valid(rgb_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [11:0] a);
    return a ^ 12'h5A5;
  endfunction

  always @(posedge clk) rom_rgb <= rom_f(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AB-1:0] a);
    addr[i*AB +: AB] = a;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    logic [N-1:0] prev_g;
    int cnt [N];

    rst_n = 1'b0; req = '0; addr = '0; lock = '0;
    tick();
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_vld", 32'(rgb_valid), 0);
    chk("reset_addr", 32'(rom_addr), 0);
    rst_n = 1'b1;

    // Sole requester 2, back-to-back grants
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      set_addr(2, 12'h123 + 12'(i));
      tick();
      chk("single_gnt", 32'(gnt), 32'h4);
      chk("single_addr", 32'(rom_addr), 32'h123 + i);
      if (i > 0) begin
        chk("single_vld", 32'(rgb_valid), 32'h4);
        chk("single_rgb", 32'(rgb), 32'(rom_f(12'h123 + 12'(i - 1))));
      end
    end
    req = '0;
    tick();
    chk("single_tail_gnt", 32'(gnt), 0);
    chk("single_tail_vld", 32'(rgb_valid), 32'h4);
    chk("single_tail_rgb", 32'(rgb), 32'(rom_f(12'h127)));
    tick();
    chk("single_done_vld", 32'(rgb_valid), 0);

    // Pointer at 3, req 1001 -> 3 then 0
    set_addr(0, 12'h0AB); set_addr(3, 12'h3CC);
    req = 4'b1001;
    tick();
    chk("wrap_gnt3", 32'(gnt), 32'h8);
    chk("wrap_addr3", 32'(rom_addr), 32'h3CC);
    req = 4'b0001;
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    chk("wrap_addr0", 32'(rom_addr), 32'h0AB);

    // Idle holds the address
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_addr", 32'(rom_addr), 32'h0AB);
    end

    // Mid-stream reset with a read in flight (pointer is 1)
    for (int i = 0; i < N; i++) set_addr(i, 12'(i * 12'h100 + 12'h10));
    req = 4'b1111;
    tick();
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_vld", 32'(rgb_valid), 0);
    chk("mid_rst_addr", 32'(rom_addr), 0);
    tick();
    chk("rst_hold_vld", 32'(rgb_valid), 0);
    rst_n = 1'b1;

    // All four requesting from reset
    for (int i = 0; i < N; i++) cnt[i] = 0;
    prev_g = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_g = 4'b0001 << (c % 4);
      chk("rr_gnt", 32'(gnt), 32'(exp_g));
      chk("rr_addr", 32'(rom_addr), (c % 4) * 32'h100 + 32'h10);
      chk("rr_vld", 32'(rgb_valid), 32'(prev_g));
      for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
      prev_g = exp_g;
    end
    for (int i = 0; i < N; i++) chk("rr_count", 32'(cnt[i]), 2);
    req = '0;
    tick();
    chk("rr_tail_vld", 32'(rgb_valid), 32'h8);
    tick();

`ifdef ROM_ARB_LOCK_EN
    // Pointer is 0; grant 1 alone, then lock it against pending 0 and 2
    req = 4'b0010; lock = 4'b0010;
    tick();
    chk("lock_first", 32'(gnt), 32'h2);
    req = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lock_hold", 32'(gnt), 32'h2);
    end
    lock = '0; req = 4'b0101;
    tick();
    chk("unlock_gnt2", 32'(gnt), 32'h4);
    req = 4'b0001;
    tick();
    chk("unlock_gnt0", 32'(gnt), 32'h1);
    req = '0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/image_rom_arbiter.md
# image_rom_arbiter

Round-robin arbiter that shares one synchronous image ROM (one-cycle registered read, 12-bit RGB out) between up to NUM_REQ pixel requesters, e.g. the background, player and barrel draw units of the game renderer. It drives the ROM address port and returns each ROM word tagged to its requester with a one-cycle valid strobe. It sits between the draw units and the ROM instance in the graphics pipeline.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- ADDR_BITS, default 12: ROM address width, `{addry, addrx}`.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester read request, level.
- addr  in  NUM_REQ*ADDR_BITS  flattened addresses; requester i uses bits [i*ADDR_BITS +: ADDR_BITS].
- gnt  out  NUM_REQ  one-hot grant, registered.
- rom_addr  out  ADDR_BITS  address to ROM, registered.
- rom_rgb  in  12  ROM data; valid one cycle after rom_addr.
- rgb  out  12  returned pixel; equals rom_rgb combinationally.
- rgb_valid  out  NUM_REQ  one-hot return strobe, registered.
- lock  in  NUM_REQ  burst lock; present only with ROM_ARB_LOCK_EN.

## Operation
- Reset: gnt=0, rgb_valid=0, rom_addr=0, priority pointer=0 (requester 0 highest).
- Each rising edge: among req bits set, select the first at or after the pointer, wrapping modulo NUM_REQ. Register gnt[sel]=1 and rom_addr=addr[sel].
- After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no request, the pointer holds.
- No request: gnt=0 and rom_addr holds its previous value.
- Return path: rgb_valid is gnt delayed one cycle. rgb is always rom_rgb; it is meaningful only while some rgb_valid bit is set.
- Handshake: a requester holds req and addr stable until it sees gnt. req still high at the edge ending the gnt cycle is a new request with the address presented then. Addresses are sampled only at the granting edge.
- A requester that drops req before being granted is simply not served. No error is raised.
- gnt and rgb_valid are each at most one-hot. At most one grant is issued per cycle.

## Timing
- Request seen at edge E → gnt and rom_addr valid during cycle E+1 → ROM registers at edge E+1 → rgb_valid and rgb valid during cycle E+2.
- Latency: two cycles from request sample to data. Throughput: one word per cycle.
- Sole continuous requester: granted every cycle, back-to-back.
- Starvation bound: a held request is granted within NUM_REQ cycles.
- Reset asserted mid-operation: gnt, rgb_valid and the pointer clear immediately. A read in flight is dropped and no rgb_valid is produced for it.

## Configuration
- ROM_ARB_LOCK_EN defined:
  - The lock port exists.
  - If the current grantee holds both req and lock at an edge, it is re-granted regardless of the pointer, and the pointer does not advance.
  - When lock drops, normal round-robin resumes, with the pointer set to grantee+1.
  - Lock without req has no effect.
- Not defined: no lock port; pure round-robin.

## Test plan
- Reset: assert rst_n=0 mid-stream → gnt=0, rgb_valid=0, rom_addr=0 within the same cycle; no stale rgb_valid after release.
- Single requester: req[2]=1 held for 5 cycles, addr[2]=0x123..0x127 → five consecutive gnt[2]; rom_addr follows; rgb_valid[2] asserts in each of the 5 cycles that follow; rgb matches ROM model.
- All four requesting continuously from reset → grant order 0,1,2,3,0,1…; each requester gets exactly one grant per 4 cycles.
- Pointer wrap: pointer at 3 (last grant to 2), req=4'b1001 → grant 3, then 0.
- Idle: req=0 for 3 cycles after a grant with addr 0x0AB → gnt=0 and rom_addr stays 0x0AB.
- With ROM_ARB_LOCK_EN: req[1] and lock[1] held for 4 cycles while req[0] and req[2] are pending → 4 consecutive gnt[1]; after lock drops, the next grant goes to 2, then 0.
